sv_bus_mux_str_ser: RTL and testbench



---
 rtl/sv_bus_mux_str_ser.sv | 107 ++++++++++
 tb/tb_sv_bus_mux_str_ser.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_bus_mux_str_ser.sv
// Bus-to-stream serializer: buffers {adr, dat} packets in a small FIFO and
// emits each one as N = (AW+DW)/SW beats with a last-beat flag.
module sv_bus_mux_str_ser #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned SW    = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned BO    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bus_vld,
  input  logic [AW-1:0]              bus_adr,
  input  logic [DW-1:0]              bus_dat,
  output logic                       bus_rdy,
  output logic                       str_vld,
  output logic [SW-1:0]              str_bus,
  output logic                       str_lst,
  input  logic                       str_rdy,
  output logic [$clog2(DEPTH+1)-1:0] pkt_lvl
);

  localparam int unsigned PW   = AW + DW;
  localparam int unsigned N    = PW / SW;
  localparam int unsigned BW   = $clog2(N);
  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW   = $clog2(DEPTH + 1);

  logic [PW-1:0]   mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic [BW-1:0]   beat_q, beat_d;

  logic            push, pop, str_xfer, beat_last;
  logic [PW-1:0]   head;
  logic [SW-1:0]   slice [N];

  assign beat_last = (beat_q == BW'(N - 1));
  assign str_vld   = (lvl_q != '0);
  assign str_xfer  = str_vld & str_rdy;
  assign pop       = str_xfer & beat_last;
  // A full FIFO still accepts when the head packet's last beat leaves this cycle.
  assign bus_rdy   = ~rst & ((lvl_q < LW'(DEPTH)) | pop);
  assign push      = bus_vld & bus_rdy;

  // Next-state for pointers, occupancy and beat counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    lvl_d    = lvl_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
    end
    // N need not be a power of two, so wrap explicitly.
    if (str_xfer) begin
      beat_d = beat_last ? '0 : beat_q + BW'(1);
    end
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  // Control state with synchronous reset; reset drops all buffered packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      beat_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
      beat_q   <= beat_d;
    end
  end

  // Packet storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus_adr, bus_dat};
    end
  end

  assign head = mem_q[rd_ptr_q];

  // Slice table in transmit order so the beat counter indexes it directly.
  for (genvar k = 0; k < N; k++) begin : g_slice
    if (BO != 0) begin : g_msb
      assign slice[k] = head[(N-1-k)*SW +: SW];
    end else begin : g_lsb
      assign slice[k] = head[k*SW +: SW];
    end
  end

  assign str_bus = slice[beat_q];
  assign str_lst = str_vld & beat_last;
  assign pkt_lvl = lvl_q;

endmodule

// File: tb/tb_sv_bus_mux_str_ser.sv
// Self-checking bench for sv_bus_mux_str_ser: four parameterisations share one
// clock and reset; scoreboards follow u0, u2 and u3, u1 is checked from a table.
module tb_sv_bus_mux_str_ser;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // u0: defaults (AW=DW=32, SW=8, DEPTH=2, BO=0)
  logic v0, br0, sv0, sl0, sr0;
  logic [31:0] a0, d0;
  logic [7:0]  sb0;
  logic [1:0]  lv0;
  // u1: BO=1
  logic v1, br1, sv1, sl1, sr1;
  logic [31:0] a1, d1;
  logic [7:0]  sb1;
  logic [1:0]  lv1;
  // u2: AW=16, DW=8, SW=8 (N=3), DEPTH=4
  logic v2, br2, sv2, sl2, sr2;
  logic [15:0] a2;
  logic [7:0]  d2, sb2;
  logic [2:0]  lv2;
  // u3: SW=32 (N=2)
  logic v3, br3, sv3, sl3, sr3;
  logic [31:0] a3, d3, sb3;
  logic [1:0]  lv3;

  sv_bus_mux_str_ser u0 (
    .clk(clk), .rst(rst), .bus_vld(v0), .bus_adr(a0), .bus_dat(d0), .bus_rdy(br0),
    .str_vld(sv0), .str_bus(sb0), .str_lst(sl0), .str_rdy(sr0), .pkt_lvl(lv0)
  );
  sv_bus_mux_str_ser #(.BO(1)) u1 (
    .clk(clk), .rst(rst), .bus_vld(v1), .bus_adr(a1), .bus_dat(d1), .bus_rdy(br1),
    .str_vld(sv1), .str_bus(sb1), .str_lst(sl1), .str_rdy(sr1), .pkt_lvl(lv1)
  );
  sv_bus_mux_str_ser #(.AW(16), .DW(8), .SW(8), .DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .bus_vld(v2), .bus_adr(a2), .bus_dat(d2), .bus_rdy(br2),
    .str_vld(sv2), .str_bus(sb2), .str_lst(sl2), .str_rdy(sr2), .pkt_lvl(lv2)
  );
  sv_bus_mux_str_ser #(.SW(32)) u3 (
    .clk(clk), .rst(rst), .bus_vld(v3), .bus_adr(a3), .bus_dat(d3), .bus_rdy(br3),
    .str_vld(sv3), .str_bus(sb3), .str_lst(sl3), .str_rdy(sr3), .pkt_lvl(lv3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboards ----------------
  logic [7:0]  q0[$];
  bit          ql0[$];
  bit          hold0;
  logic [7:0]  hold0_b;
  logic [63:0] p0;

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      ql0.delete();
      hold0 = 1'b0;
    end else begin
      if (hold0) begin
        check("u0_stall_vld", sv0, 1);
        check("u0_stall_bus", sb0, hold0_b);
      end
      if (v0 && br0) begin
        p0 = {a0, d0};
        for (int k = 0; k < 8; k++) begin
          q0.push_back(8'(p0 >> (8 * k)));
          ql0.push_back(k == 7);
        end
      end
      if (sv0 && sr0) begin
        if (q0.size() == 0) check("u0_extra_beat", 1, 0);
        else begin
          check("u0_beat", sb0, q0.pop_front());
          check("u0_lst", sl0, ql0.pop_front());
        end
      end
      hold0   = sv0 && !sr0;
      hold0_b = sb0;
    end
  end

  logic [7:0]  q2[$];
  bit          ql2[$];
  logic [23:0] p2;
  int          b2 = 0;
  int          l2 = 0;

  always @(negedge clk) begin
    if (rst) begin
      q2.delete();
      ql2.delete();
    end else begin
      if (v2 && br2) begin
        p2 = {a2, d2};
        for (int k = 0; k < 3; k++) begin
          q2.push_back(8'(p2 >> (8 * k)));
          ql2.push_back(k == 2);
        end
      end
      if (sv2 && sr2) begin
        b2++;
        if (sl2) l2++;
        if (q2.size() == 0) check("u2_extra_beat", 1, 0);
        else begin
          check("u2_beat", sb2, q2.pop_front());
          check("u2_lst", sl2, ql2.pop_front());
        end
      end
    end
  end

  logic [31:0] q3[$];
  bit          ql3[$];
  int          b3 = 0;

  always @(negedge clk) begin
    if (rst) begin
      q3.delete();
      ql3.delete();
    end else begin
      if (v3 && br3) begin
        q3.push_back(d3);
        ql3.push_back(1'b0);
        q3.push_back(a3);
        ql3.push_back(1'b1);
      end
      if (sv3 && sr3) begin
        b3++;
        if (q3.size() == 0) check("u3_extra_beat", 1, 0);
        else begin
          check("u3_beat", sb3, q3.pop_front());
          check("u3_lst", sl3, ql3.pop_front());
        end
      end
    end
  end

  // ---------------- bus senders (start and end at posedge+1) ----------------
  task automatic send0(input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    a0 = a; d0 = d; v0 = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = br0;
      tick();
    end
    v0 = 1'b0;
    check("u0_send_accept", ok, 1);
  endtask

  task automatic send2(input logic [15:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    a2 = a; d2 = d; v2 = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = br2;
      tick();
    end
    v2 = 1'b0;
    check("u2_send_accept", ok, 1);
  endtask

  task automatic send3(input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    a3 = a; d3 = d; v3 = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = br3;
      tick();
    end
    v3 = 1'b0;
    check("u3_send_accept", ok, 1);
  endtask

  // Expected beats listed first-beat-in-MSB-byte.
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [63:0] exp_lsb;
    logic [63:0] exp_msb;
  } vec_t;
  vec_t vt[3];

  int  beats;
  bit  acc;
  bit  done2;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h0403_0201, 32'h0807_0605, 64'h0506_0708_0102_0304, 64'h0403_0201_0807_0605};
    vt[1] = '{32'hDEAD_BEEF, 32'h0123_4567, 64'h6745_2301_EFBE_ADDE, 64'hDEAD_BEEF_0123_4567};
    vt[2] = '{32'hA5A5_0F0F, 32'hFFFF_0000, 64'h0000_FFFF_0F0F_A5A5, 64'hA5A5_0F0F_FFFF_0000};

    rst = 1'b1;
    {v0, v1, v2, v3} = '0;
    {sr0, sr1, sr2, sr3} = '0;
    a0 = '0; d0 = '0; a1 = '0; d1 = '0; a2 = '0; d2 = '0; a3 = '0; d3 = '0;
    done2 = 1'b0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("rst_u0_vld", sv0, 0);
    check("rst_u0_lst", sl0, 0);
    check("rst_u0_lvl", lv0, 0);
    check("rst_u0_rdy", br0, 0);
    check("rst_u1_vld", sv1, 0);
    check("rst_u1_lvl", lv1, 0);
    check("rst_u2_vld", sv2, 0);
    check("rst_u2_rdy", br2, 0);
    check("rst_u3_vld", sv3, 0);
    check("rst_u3_lvl", lv3, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("u0_rdy_after_rst", br0, 1);
    tick();

    // Table: single packets, BO=0 on u0 and BO=1 on u1, str_rdy high
    sr0 = 1'b1;
    sr1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a0 = vt[i].adr; d0 = vt[i].dat; v0 = 1'b1;
      a1 = vt[i].adr; d1 = vt[i].dat; v1 = 1'b1;
      @(negedge clk);
      check("tbl_rdy_idle", br0, 1);
      check("tbl_vld_idle", sv0, 0);
      tick();
      v0 = 1'b0;
      v1 = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        check("tbl_vld_bo0", sv0, 1);
        check("tbl_bus_bo0", sb0, 8'(vt[i].exp_lsb >> (56 - 8 * k)));
        check("tbl_lst_bo0", sl0, k == 7);
        check("tbl_lvl_bo0", lv0, 1);
        check("tbl_vld_bo1", sv1, 1);
        check("tbl_bus_bo1", sb1, 8'(vt[i].exp_msb >> (56 - 8 * k)));
        check("tbl_lst_bo1", sl1, k == 7);
        tick();
      end
      @(negedge clk);
      check("tbl_drained_vld_bo0", sv0, 0);
      check("tbl_drained_lvl_bo0", lv0, 0);
      check("tbl_drained_vld_bo1", sv1, 0);
      tick();
    end

    // N=2: back-to-back packets, last flag alternates
    sr3 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      send3(32'h1111_1111 * i, ~(32'h1111_1111 * i));
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!sv3) break;
      tick();
    end
    tick();
    check("u3_beat_count", b3, 6);
    check("u3_sb_empty", q3.size(), 0);

    // Back-pressure: fill DEPTH=2, third write waits for first packet's last beat
    sr0 = 1'b0;
    send0(32'h1357_9BDF, 32'h8877_66A5);
    send0(32'h2468_ACE0, 32'h0F1E_2D3C);
    a0 = 32'hCAFE_F00D; d0 = 32'h7654_3210; v0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_lvl_full", lv0, 2);
      check("bp_rdy_low", br0, 0);
      check("bp_bus_beat0", sb0, 8'hA5);
      tick();
    end
    sr0 = 1'b1;
    beats = 0;
    acc = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!sv0) break;
      beats++;
      if (c == 8) check("bp_lvl_after_swap", lv0, 2);
      if (v0 && br0) begin
        check("bp_accept_cycle", c, 7);
        check("bp_accept_on_last", sl0, 1);
        acc = 1'b1;
      end
      tick();
      if (acc) v0 = 1'b0;
    end
    v0 = 1'b0;
    tick();
    check("bp_accepted", acc, 1);
    check("bp_beats_no_gap", beats, 24);
    check("bp_sb_empty", q0.size(), 0);

    // Reset mid-packet with a second packet queued
    send0(32'h0A0B_0C0D, 32'h0102_0304);
    send0(32'h1A1B_1C1D, 32'h1112_1314);
    repeat (3) begin
      @(negedge clk);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy_low", br0, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_vld", sv0, 0);
    check("mid_rst_lvl", lv0, 0);
    check("mid_rst_lst", sl0, 0);
    tick();
    send0(32'h5566_7788, 32'h99AA_BBCC);
    @(negedge clk);
    check("mid_rst_new_vld", sv0, 1);
    check("mid_rst_new_beat0", sb0, 8'hCC);
    for (int c = 0; c < 50; c++) begin
      if (!sv0) break;
      tick();
      @(negedge clk);
    end
    check("mid_rst_drained", sv0, 0);
    check("mid_rst_sb_empty", q0.size(), 0);
    tick();

    // Random stalls, N=3
    fork
      begin : g_prod
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          send2(16'($urandom), 8'($urandom));
        end
        done2 = 1'b1;
      end
      begin : g_stall
        int c;
        c = 0;
        while (!(done2 && lv2 == 0 && !v2) && c < 5000) begin
          sr2 = ($urandom_range(0, 3) != 0);
          tick();
          c++;
        end
        check("rnd_finished_in_budget", c < 5000, 1);
      end
    join
    sr2 = 1'b1;
    tick();
    check("rnd_beat_count", b2, 300);
    check("rnd_lst_count", l2, 100);
    check("rnd_sb_empty", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
